// File: rtl/data_mem_ctrl.sv
// Word-organised data memory behind a fixed-latency load/store port.
// Byte/half/word lanes, alignment and range faults, completion counter.
module data_mem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 32,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [15:0] access_cnt
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_t;

  state_t          state_q;
  logic [3:0]      wcnt_q;
  logic            we_q;
  logic            sx_q;
  logic            flt_q;
  logic [1:0]      size_q;
  logic [31:0]     wdata_q;
  logic [AW+1:0]   off_q;
  logic            busy_q;
  logic            ready_q;
  logic            fault_q;
  logic [31:0]     rdata_q;
  logic [15:0]     access_cnt_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     off_d;
  logic            flt_d;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word_r;
  logic [31:0]     shifted;
  logic [31:0]     ld_val;
  logic [31:0]     st_word;
  logic            do_store;

  // Offset decode and fault classification at acceptance time
  always_comb begin
    off_d = addr - ADDR_BASE;
    flt_d = (size == 2'b11)
          | ((size == 2'b01) & off_d[0])
          | ((size == 2'b10) & (|off_d[1:0]))
          | (off_d >= LIMIT);
  end

  assign idx    = off_q[AW+1:2];
  assign lane   = off_q[1:0];
  assign word_r = mem[idx];

  // Load lane extraction with optional sign extension
  always_comb begin
    shifted = word_r >> {lane, 3'b000};
    ld_val  = word_r;
    case (size_q)
      2'b00:
        ld_val = sx_q ? {{24{shifted[7]}}, shifted[7:0]}
                      : {24'b0, shifted[7:0]};
      2'b01:
        ld_val = sx_q ? {{16{shifted[15]}}, shifted[15:0]}
                      : {16'b0, shifted[15:0]};
      default:
        ld_val = word_r;
    endcase
  end

  // Store merge: only the addressed lanes change
  always_comb begin
    st_word = word_r;
    case (size_q)
      2'b00:   st_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   st_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_word = wdata_q;
    endcase
  end

  assign do_store = rst_n & (state_q == ACCESS) & we_q & ~flt_q;

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (do_store) mem[idx] <= st_word;
  end

  // Access sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      we_q         <= 1'b0;
      sx_q         <= 1'b0;
      flt_q        <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      access_cnt_q <= '0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            sx_q    <= sign_ext;
            size_q  <= size;
            wdata_q <= wdata;
            off_q   <= off_d[AW+1:0];
            flt_q   <= flt_d;
            busy_q  <= 1'b1;
            if (WC == 4'd0) begin
              state_q <= ACCESS;
              wcnt_q  <= '0;
            end else begin
              state_q <= WAIT;
              wcnt_q  <= WC;
            end
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q <= 4'd1) state_q <= ACCESS;
        end
        ACCESS: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          fault_q <= flt_q;
          if (!flt_q) begin
            access_cnt_q <= access_cnt_q + 16'd1;
            if (!we_q) rdata_q <= ld_val;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign ready      = ready_q;
  assign rdata      = rdata_q;
  assign fault      = fault_q;
  assign access_cnt = access_cnt_q;

endmodule
